// File: rtl/window_buffer_pkg.sv
// window_buffer shared types and widths.
package window_buffer_pkg;

    localparam int PIXEL_W = 8;
    localparam int WIN_W   = 72;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        OUT
    } state_t;

endpackage

// File: rtl/window_buffer_if.sv
// Pixel, Sobel and result handshake bundle for window_buffer.
interface window_buffer_if;
    import window_buffer_pkg::*;

    logic [PIXEL_W-1:0] pixel_in;
    logic               pixel_valid;
    logic               pixel_ready;
    logic [WIN_W-1:0]   image_buffer;
    logic               enable;
    logic [PIXEL_W-1:0] new_pixel;
    logic               done;
    logic [PIXEL_W-1:0] out_pixel;
    logic               out_valid;
    logic               out_ready;
    logic               frame_done;
    logic               timeout_err;

    modport master (
        output pixel_in, pixel_valid, new_pixel, done, out_ready,
        input  pixel_ready, image_buffer, enable, out_pixel,
        input  out_valid, frame_done, timeout_err
    );

    modport slave (
        input  pixel_in, pixel_valid, new_pixel, done, out_ready,
        output pixel_ready, image_buffer, enable, out_pixel,
        output out_valid, frame_done, timeout_err
    );

endinterface

// File: rtl/window_buffer_line_buffer.sv
// Two-row line store: combinational read, write on the clock edge.
module line_buffer #(
    parameter int DEPTH = 640
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [15:0]              wdata,
    output logic [15:0]              rdata
);

    logic [15:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/window_buffer.sv
// window_buffer: raster pixels in, 3x3 windows to Sobel, results out.
// Optional done-timeout enabled by WINDOW_BUF_TIMEOUT_EN.
module window_buffer
    import window_buffer_pkg::*;
#(
    parameter int IMG_WIDTH      = 640,
    parameter int IMG_HEIGHT     = 480,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic           clk,
    input logic           n_rst,
    window_buffer_if.slave bus
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);

    state_t state_q, state_d;

    logic [CW-1:0]      col;
    logic [RW-1:0]      row;
    logic [PIXEL_W-1:0] win [9];
    logic [15:0]        lb_rd;
    logic [PIXEL_W-1:0] a, b;
    logic               accept;
    logic               win_ok;
    logic               at_end;
    logic               last_q;
    logic               timeout;

    logic               ready_q;
    logic               enable_q;
    logic               valid_q;
    logic               fdone_q;
    logic [PIXEL_W-1:0] opix_q;
    logic [WIN_W-1:0]   ib;

    assign accept = (state_q == IDLE) && bus.pixel_valid;
    assign win_ok = (row >= RW'(2)) && (col >= CW'(2));
    assign at_end = (row == ROW_MAX) && (col == COL_MAX);
    assign a      = lb_rd[15:8];
    assign b      = lb_rd[7:0];

    line_buffer #(
        .DEPTH (IMG_WIDTH)
    ) u_lb (
        .clk   (clk),
        .we    (accept),
        .addr  (col),
        .wdata ({bus.pixel_in, a}),
        .rdata (lb_rd)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept && win_ok) state_d = BUSY;
            BUSY: if (bus.done || timeout) state_d = OUT;
            OUT:  if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            col      <= '0;
            row      <= '0;
            last_q   <= 1'b0;
            ready_q  <= 1'b1;
            enable_q <= 1'b0;
            valid_q  <= 1'b0;
            fdone_q  <= 1'b0;
            opix_q   <= '0;
            for (int k = 0; k < 9; k++) begin
                win[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            ready_q  <= (state_d == IDLE);
            enable_q <= (state_d == BUSY);
            valid_q  <= (state_d == OUT);
            fdone_q  <= (state_q == OUT) && bus.out_ready && last_q;
            if (accept) begin
                last_q <= at_end;
                if (col == COL_MAX) begin
                    col <= '0;
                    row <= (row == ROW_MAX) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                // oldest column drops off the left, new column enters right
                win[0] <= win[1];
                win[1] <= win[2];
                win[2] <= b;
                win[3] <= win[4];
                win[4] <= win[5];
                win[5] <= a;
                win[6] <= win[7];
                win[7] <= win[8];
                win[8] <= bus.pixel_in;
            end
            if (state_q == BUSY) begin
                if (bus.done) begin
                    opix_q <= bus.new_pixel;
                end else if (timeout) begin
                    opix_q <= '0;
                end
            end
        end
    end

`ifdef WINDOW_BUF_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tcnt;
    logic          to_err;

    assign timeout = (state_q == BUSY) && !bus.done &&
                     (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            tcnt   <= '0;
            to_err <= 1'b0;
        end else begin
            tcnt <= (state_q == BUSY) ? tcnt + TW'(1) : '0;
            if (timeout) begin
                to_err <= 1'b1;
            end
        end
    end

    assign bus.timeout_err = to_err;
`else
    assign timeout         = 1'b0 && (TIMEOUT_CYCLES > 0);
    assign bus.timeout_err = 1'b0;
`endif

    always_comb begin
        ib = '0;
        for (int k = 0; k < 9; k++) begin
            ib[8*k +: 8] = win[k];
        end
    end

    assign bus.pixel_ready  = ready_q;
    assign bus.enable       = enable_q;
    assign bus.image_buffer = ib;
    assign bus.out_pixel    = opix_q;
    assign bus.out_valid    = valid_q;
    assign bus.frame_done   = fdone_q;

endmodule

// File: tb/tb_window_buffer.sv
// Randomised self-checking bench for window_buffer on a 4x4 frame.
module tb_window_buffer;
    import window_buffer_pkg::*;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int TO = 16;
    localparam int PER_FRAME = (W - 2) * (H - 2);

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   img [H][W];

    always #5 clk = ~clk;

    window_buffer_if bus ();

    window_buffer #(
        .IMG_WIDTH      (W),
        .IMG_HEIGHT     (H),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [71:0] got,
                         input logic [71:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // window of the 3x3 neighbourhood ending at (r,c), k=0 top-left
    function automatic logic [71:0] win_of(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            w[8*k +: 8] = 8'(img[r - 2 + k / 3][c - 2 + k % 3]);
        end
        return w;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b0;
        bus.pixel_valid = 1'b0;
        bus.pixel_in = '0;
        bus.done = 1'b0;
        bus.new_pixel = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rdy", 72'(bus.pixel_ready), 72'd1);
        check("rst_en", 72'(bus.enable), 72'd0);
        check("rst_ib", bus.image_buffer, 72'd0);
        check("rst_opix", 72'(bus.out_pixel), 72'd0);
        check("rst_ov", 72'(bus.out_valid), 72'd0);
        check("rst_fd", 72'(bus.frame_done), 72'd0);
        check("rst_err", 72'(bus.timeout_err), 72'd0);
        n_rst = 1'b1;
    endtask

    // mode 0: directed seq, 1: slow Sobel, 2: backpressure, 3: random
    task automatic run(input int frames, input int mode);
        int n_total, n_sent, exp_res, results, fd_cnt;
        int busy, delay, bp, cyc, mr, mc, wi;
        bit in_busy, lat, post, fd_exp, first_seen;
        logic [71:0] cur;
        logic [71:0] ref_win [PER_FRAME];
        logic [7:0] exp_out;
        logic [71:0] q [$];
        n_total = frames * W * H;
        exp_res = frames * PER_FRAME;
        n_sent = 0; results = 0; fd_cnt = 0;
        busy = 0; delay = 0; bp = 0; cyc = 0;
        mr = 0; mc = 0; wi = 0;
        in_busy = 0; lat = 0; post = 0; fd_exp = 0;
        first_seen = 0; cur = '0; exp_out = '0;
        while ((results < exp_res || n_sent < n_total || fd_exp)
               && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (lat) check("en_lat", 72'(bus.enable), 72'd1);
            lat = 0;
            if (post) begin
                check("done_en", 72'(bus.enable), 72'd0);
                check("done_ov", 72'(bus.out_valid), 72'd1);
                post = 0;
            end
            check("fdone", 72'(bus.frame_done), 72'(fd_exp));
            if (bus.frame_done) fd_cnt++;
            fd_exp = 0;

            bus.done = 1'b0;
            bus.new_pixel = 8'($urandom);
            if (bus.enable) begin
                check("rdy_busy", 72'(bus.pixel_ready), 72'd0);
                if (!in_busy) begin
                    in_busy = 1;
                    busy = 0;
                    cur = (q.size() > 0) ? q.pop_front() : 'x;
                    delay = (mode == 1) ? 5 :
                            (mode == 3) ? $urandom_range(0, 6) : 0;
                    if (mode == 0 && !first_seen) begin
                        first_seen = 1;
                        check("first_n", 72'(n_sent), 72'd11);
                        check("first_win", bus.image_buffer,
                              72'h0b_0a_09_07_06_05_03_02_01);
                    end
                    if (mode == 0) begin
                        if (wi < PER_FRAME) ref_win[wi] = bus.image_buffer;
                        else check("b2b", bus.image_buffer,
                                   ref_win[wi % PER_FRAME]);
                        wi++;
                    end
                    check("win", bus.image_buffer, cur);
                end else begin
                    check("win_hold", bus.image_buffer, cur);
                end
                if (busy == delay) begin
                    exp_out = (mode == 0) ? 8'h19 :
                              (mode == 1) ? 8'hAB : 8'($urandom);
                    bus.done = 1'b1;
                    bus.new_pixel = exp_out;
                    post = 1;
                    in_busy = 0;
                    bp = (mode == 2) ? 4 :
                         (mode == 3) ? $urandom_range(0, 3) : 0;
                end else begin
                    busy++;
                end
            end else if (mode == 3 && $urandom_range(0, 3) == 0) begin
                bus.done = 1'b1;
            end

            bus.out_ready = (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.out_valid) begin
                check("opix", 72'(bus.out_pixel), 72'(exp_out));
                check("rdy_out", 72'(bus.pixel_ready), 72'd0);
                if (bp > 0) begin
                    bus.out_ready = 1'b0;
                    bp--;
                end else begin
                    bus.out_ready = 1'b1;
                    results++;
                    if (results % PER_FRAME == 0) fd_exp = 1;
                end
            end

            if (n_sent < n_total) begin
                bus.pixel_valid = (mode == 3) ?
                                  ($urandom_range(0, 3) != 0) : 1'b1;
                bus.pixel_in = (mode == 3) ? 8'($urandom) :
                               8'(n_sent % (W * H) + 1);
                if (bus.pixel_valid && bus.pixel_ready) begin
                    img[mr][mc] = int'(bus.pixel_in);
                    if (mr >= 2 && mc >= 2) begin
                        q.push_back(win_of(mr, mc));
                        lat = 1;
                    end
                    if (mc == W - 1) begin
                        mc = 0;
                        mr = (mr == H - 1) ? 0 : mr + 1;
                    end else begin
                        mc++;
                    end
                    n_sent++;
                end
            end else begin
                bus.pixel_valid = 1'b0;
            end
        end
        bus.pixel_valid = 1'b0;
        bus.done = 1'b0;
        check("budget", 72'(cyc < 3000), 72'd1);
        check("n_res", 72'(results), 72'(exp_res));
        check("n_fdone", 72'(fd_cnt), 72'(frames));
        check("q_empty", 72'(q.size()), 72'd0);
    endtask

    task automatic busy_reset_test();
        int n;
        do_reset();
        bus.done = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            bus.pixel_valid = 1'b1;
            bus.pixel_in = 8'(i);
            @(negedge clk);
        end
        bus.pixel_valid = 1'b0;
        check("bz_en", 72'(bus.enable), 72'd1);
`ifdef WINDOW_BUF_TIMEOUT_EN
        n = 0;
        while (bus.enable && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("to_len", 72'(n), 72'(TO));
        check("to_ov", 72'(bus.out_valid), 72'd1);
        check("to_pix", 72'(bus.out_pixel), 72'd0);
        check("to_err", 72'(bus.timeout_err), 72'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("to_idle", 72'(bus.pixel_ready), 72'd1);
        bus.pixel_valid = 1'b1;
        bus.pixel_in = 8'd12;
        @(negedge clk);
        bus.pixel_valid = 1'b0;
        check("bz_en2", 72'(bus.enable), 72'd1);
`else
        n = 0;
`endif
        repeat (3) @(negedge clk);
        check("bz_hold", 72'(bus.enable), 72'd1);
        check("bz_rdy", 72'(bus.pixel_ready), 72'd0);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        check("mid_en", 72'(bus.enable), 72'd0);
        check("mid_rdy", 72'(bus.pixel_ready), 72'd1);
        check("mid_ov", 72'(bus.out_valid), 72'd0);
        check("mid_err", 72'(bus.timeout_err), 72'd0);
    endtask

    initial begin
        bus.pixel_valid = 1'b0;
        bus.pixel_in = '0;
        bus.done = 1'b0;
        bus.new_pixel = '0;
        bus.out_ready = 1'b0;
        do_reset();
        run(1, 0);
        do_reset();
        run(2, 0);
        do_reset();
        run(1, 1);
        do_reset();
        run(1, 2);
        do_reset();
        run(6, 3);
        busy_reset_test();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/window_buffer.md
# window_buffer

Raster-scan pixel front end for the Sobel datapath. It accepts an 8-bit grayscale pixel stream and keeps two line buffers plus a 3x3 window. For every interior pixel it presents the 72-bit window to `sobelBlock` (drives its `image_buffer`/`enable` and consumes its `new_pixel`/`done`), then forwards each edge result downstream on a valid/ready stream. Border pixels are consumed and produce no output, so a W x H frame yields (W-2)*(H-2) results.

## Interface
- `IMG_WIDTH`, default 640: pixels per row; must be ≥3.
- `IMG_HEIGHT`, default 480: rows per frame; must be ≥3.
- `TIMEOUT_CYCLES`, default 16: cycles to wait for `done`; used only with `WINDOW_BUF_TIMEOUT_EN`.
- `clk`  in  1  single clock; all logic on the rising edge.
- `n_rst`  in  1  reset; synchronous and active-low.
- `pixel_in`  in  8  input pixel, raster order.
- `pixel_valid`  in  1  `pixel_in` is valid.
- `pixel_ready`  out  1  buffer can accept a pixel.
- `image_buffer`  out  72  3x3 window to the Sobel block.
- `enable`  out  1  window valid; Sobel block computes.
- `new_pixel`  in  8  Sobel result.
- `done`  in  1  `new_pixel` is valid.
- `out_pixel`  out  8  result stream data.
- `out_valid`  out  1  `out_pixel` is valid.
- `out_ready`  in  1  downstream accepts.
- `frame_done`  out  1  one-cycle pulse when the last result of a frame is accepted.
- `timeout_err`  out  1  sticky timeout flag.

## Operation
- **Window byte map:** `image_buffer[8k+7:8k]` holds window position k, raster order: k=0 top-left, k=2 top-right, k=4 centre, k=8 bottom-right (the newest pixel).
- **Line buffer:** depth IMG_WIDTH, 16 bits wide, entry `{row r-1, row r-2}` at the current column.
  - Read is combinational; write happens at the accept edge.
  - On accept: read `{a,b}`, then write `{pixel_in, a}`.
  - New window column = `{b, a, pixel_in}` (top to bottom). Window columns shift left; the new column enters on the right.
- **Counters:** `col` (0..W-1) and `row` (0..H-1) track the accepted pixel.
  - `col` wraps at W-1 and increments `row`.
  - `row` wraps at H-1 at the end of the frame.
  - The next pixel starts the next frame with no idle gap required.
- **Window-valid rule:** the accepted pixel has `row≥2 && col≥2`. Stale column registers across a row wrap are harmless because of this gating.
- **FSM states:** IDLE, BUSY, OUT.
  - IDLE: `pixel_ready`=1. An accept with window-valid goes to BUSY; an accept without window-valid stays in IDLE.
  - BUSY: `enable`=1 and `image_buffer` held stable. On `done`=1, capture `new_pixel` into `out_pixel` and go to OUT. `done` may arrive in the first BUSY cycle.
  - OUT: `out_valid`=1 and `out_pixel` held stable. On `out_ready`=1, go to IDLE. If this was the frame's last pixel (row H-1, col W-1), pulse `frame_done` in the same cycle as the handshake.
- `done` outside BUSY is ignored. `pixel_ready` is 0 in BUSY and OUT.
- **Reset:** `n_rst`=0 at any edge, in any state (including mid-BUSY or mid-OUT), returns to IDLE with counters at 0. Line buffer contents are not cleared; gating makes them don't-care.

## Timing
- **Reset values:** `pixel_ready`=1, `enable`=0, `image_buffer`=0, `out_pixel`=0, `out_valid`=0, `frame_done`=0, `timeout_err`=0.
- Accept at edge t → `enable`=1 from t+1.
- `done` sampled at edge k → `enable`=0 and `out_valid`=1 from k+1.
- **Peak rate:** 1 pixel/cycle for non-window pixels; 3 cycles per window pixel when `done` is immediate and `out_ready` is high.
- All outputs are registered.

## Configuration
- Macro `WINDOW_BUF_TIMEOUT_EN`.
- **Defined:** a counter runs in BUSY. If `done` has not arrived after TIMEOUT_CYCLES cycles in BUSY:
  - emit `out_pixel`=0 and go to OUT;
  - set `timeout_err` (sticky until reset).
- **Undefined:** BUSY waits indefinitely and `timeout_err` is tied 0.

## Structure
- **Package `window_buffer_pkg`:** state enum (IDLE/BUSY/OUT), `PIXEL_W`=8, `WIN_W`=72.
- **Sub-module `line_buffer`:** parameterised depth, 16-bit wide, combinational read, synchronous write.

## Test plan
- **Reset:** hold `n_rst`=0 for 2 cycles → all outputs at their reset values, `pixel_ready`=1.
- **4x4 frame:** IMG_WIDTH=IMG_HEIGHT=4, pixels 1..16, `done` returned immediately with `new_pixel`=0x19, `out_ready`=1.
  - First `enable` comes one cycle after pixel 11 is accepted.
  - Its `image_buffer` bytes k0..k8 = 1,2,3,5,6,7,9,10,11.
  - Exactly 4 results are produced; `frame_done` pulses once, with the 4th.
- **Slow Sobel block:** hold `done` low for 5 cycles, then `new_pixel`=0xAB → `enable` and `image_buffer` stay stable and `pixel_ready`=0 throughout; `out_pixel`=0xAB one cycle after `done`.
- **Backpressure:** `out_ready`=0 for 4 cycles → `out_valid` and `out_pixel` hold; no new pixel is accepted; the transfer completes on the first `out_ready`=1.
- **Back-to-back frames:** two identical 4x4 frames sent with no gap → identical window sequences and two `frame_done` pulses.
- **Timeout (`WINDOW_BUF_TIMEOUT_EN` defined) and reset mid-BUSY:**
  - Never assert `done` → after 16 BUSY cycles, `out_pixel`=0 and `timeout_err`=1.
  - Then assert `n_rst`=0 during BUSY → next cycle is IDLE with `enable`=0 and `timeout_err`=0.
